// File: rtl/vreg_operand_fetch.sv
// Decode-stage operand fetch for the 4-entry, 256-bit vector register file.
// Drives RF read addresses, captures operands a cycle later, and stalls on RAW/WAW via a busy scoreboard.
module vreg_operand_fetch (
  input  logic         RST,
  input  logic         CLK_DC,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [4:0]   IN_RS1,
  input  logic [4:0]   IN_RS2,
  input  logic [4:0]   IN_RD,
  input  logic         IN_USE_RS1,
  input  logic         IN_USE_RS2,
  input  logic         IN_WRITES_RD,
  output logic [4:0]   A1,
  output logic [4:0]   A2,
  input  logic [255:0] RD1,
  input  logic [255:0] RD2,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [255:0] OUT_OP1,
  output logic [255:0] OUT_OP2,
  output logic [4:0]   OUT_RD,
  output logic         OUT_WE,
  input  logic         RETIRE_VALID,
  input  logic [4:0]   RETIRE_ADDR,
  output logic [3:0]   BUSY_MASK
);

  // IDLE: accept when hazard-free | ADDR: RF samples A1/A2 | DATA: capture RD1/RD2 | HOLD: present bundle
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_e;

  state_e       state_q;
  logic [3:0]   busy_q, busy_d;
  logic [4:0]   a1_q, a2_q, rd_q, out_rd_q;
  logic         use1_q, use2_q, we_q;
  logic         out_we_q, out_valid_q;
  logic [255:0] op1_q, op2_q;
  logic         hazard, accept;
  logic         unused_retire_hi;

  assign hazard = (IN_USE_RS1   & busy_q[IN_RS1[1:0]]) |
                  (IN_USE_RS2   & busy_q[IN_RS2[1:0]]) |
                  (IN_WRITES_RD & busy_q[IN_RD[1:0]]);

  assign IN_READY = (state_q == S_IDLE) & ~hazard;
  assign accept   = IN_VALID & IN_READY;

  // Set is applied after clear so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (RETIRE_VALID) busy_d[RETIRE_ADDR[1:0]] = 1'b0;
    if (accept & IN_WRITES_RD) busy_d[IN_RD[1:0]] = 1'b1;
  end

  assign unused_retire_hi = ^RETIRE_ADDR[4:2];

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      rd_q        <= '0;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      we_q        <= 1'b0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a1_q    <= IN_RS1;
            a2_q    <= IN_RS2;
            rd_q    <= IN_RD;
            use1_q  <= IN_USE_RS1;
            use2_q  <= IN_USE_RS2;
            we_q    <= IN_WRITES_RD;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: state_q <= S_DATA;
        S_DATA: begin
          op1_q       <= use1_q ? RD1 : '0;
          op2_q       <= use2_q ? RD2 : '0;
          out_rd_q    <= rd_q;
          out_we_q    <= we_q;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign A1        = a1_q;
  assign A2        = a2_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_OP1   = op1_q;
  assign OUT_OP2   = op2_q;
  assign OUT_RD    = out_rd_q;
  assign OUT_WE    = out_we_q;
  assign BUSY_MASK = busy_q;

endmodule

// File: tb/tb_vreg_operand_fetch.sv
// Bench for vreg_operand_fetch: directed scenarios plus a randomized run against
// a timestamp-based model of the scoreboard and operand bundle.
module tb_vreg_operand_fetch;

  logic         RST, CLK_DC;
  logic         IN_VALID, IN_READY;
  logic [4:0]   IN_RS1, IN_RS2, IN_RD;
  logic         IN_USE_RS1, IN_USE_RS2, IN_WRITES_RD;
  logic [4:0]   A1, A2;
  logic [255:0] RD1, RD2;
  logic         OUT_VALID, OUT_READY;
  logic [255:0] OUT_OP1, OUT_OP2;
  logic [4:0]   OUT_RD;
  logic         OUT_WE;
  logic         RETIRE_VALID;
  logic [4:0]   RETIRE_ADDR;
  logic [3:0]   BUSY_MASK;

  logic [255:0] regs [4];
  int errors = 0;
  int checks = 0;

  vreg_operand_fetch dut (
    .RST(RST), .CLK_DC(CLK_DC),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD),
    .IN_USE_RS1(IN_USE_RS1), .IN_USE_RS2(IN_USE_RS2), .IN_WRITES_RD(IN_WRITES_RD),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_OP1(OUT_OP1), .OUT_OP2(OUT_OP2), .OUT_RD(OUT_RD), .OUT_WE(OUT_WE),
    .RETIRE_VALID(RETIRE_VALID), .RETIRE_ADDR(RETIRE_ADDR),
    .BUSY_MASK(BUSY_MASK)
  );

  initial CLK_DC = 1'b0;
  always #5 CLK_DC = ~CLK_DC;

  // Register file: read data registered on CLK_DC
  always @(posedge CLK_DC) begin
    RD1 <= regs[A1[1:0]];
    RD2 <= regs[A2[1:0]];
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK_DC);
    #1;
  endtask

  task automatic clear_inputs();
    IN_VALID = 0; IN_RS1 = 0; IN_RS2 = 0; IN_RD = 0;
    IN_USE_RS1 = 0; IN_USE_RS2 = 0; IN_WRITES_RD = 0;
    RETIRE_VALID = 0; RETIRE_ADDR = 0;
  endtask

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic w);
    IN_VALID = 1; IN_RS1 = rs1; IN_RS2 = rs2; IN_RD = rd;
    IN_USE_RS1 = u1; IN_USE_RS2 = u2; IN_WRITES_RD = w;
  endtask

  task automatic do_reset();
    RST = 0;
    step();
    step();
    RST = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 0;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", OUT_VALID); end
    checks++; if (BUSY_MASK !== 4'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", BUSY_MASK); end
    checks++; if (A1 !== 5'd0 || A2 !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0h/%0h exp=0/0", A1, A2); end
    checks++; if (OUT_OP1 !== '0 || OUT_OP2 !== '0) begin errors++; $display("FAIL reset_ops got=%0h/%0h exp=0/0", OUT_OP1, OUT_OP2); end
    checks++; if (OUT_RD !== 5'd0 || OUT_WE !== 1'b0) begin errors++; $display("FAIL reset_rd_we got=%0h/%0h exp=0/0", OUT_RD, OUT_WE); end
    step();
    step();
    RST = 1;
    present(5'd7, 5'd14, 5'd31, 1, 1, 1);
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", IN_READY); end
    clear_inputs();
  endtask

  task automatic test_basic();
    regs[1] = 256'hA; regs[2] = 256'hB;
    OUT_READY = 1;
    present(5'd1, 5'd2, 5'd3, 1, 1, 1);
    step();
    clear_inputs();
    checks++; if (A1 !== 5'd1 || A2 !== 5'd2) begin errors++; $display("FAIL basic_addr got=%0h/%0h exp=1/2", A1, A2); end
    checks++; if (BUSY_MASK !== 4'b1000) begin errors++; $display("FAIL basic_busy got=%0b exp=1000", BUSY_MASK); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0h exp=0", OUT_VALID); end
    step();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_valid_n1 got=%0h exp=0", OUT_VALID); end
    step();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid_n2 got=%0h exp=1", OUT_VALID); end
    checks++; if (OUT_OP1 !== 256'hA || OUT_OP2 !== 256'hB) begin errors++; $display("FAIL basic_ops got=%0h/%0h exp=a/b", OUT_OP1, OUT_OP2); end
    checks++; if (OUT_RD !== 5'd3 || OUT_WE !== 1'b1) begin errors++; $display("FAIL basic_rd_we got=%0h/%0h exp=3/1", OUT_RD, OUT_WE); end
    step();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_handoff got=%0h exp=0", OUT_VALID); end
  endtask

  task automatic test_raw();
    logic [255:0] newval;
    newval = rand256();
    checks++; if (BUSY_MASK !== 4'b1000) begin errors++; $display("FAIL raw_pre_busy got=%0b exp=1000", BUSY_MASK); end
    present(5'd3, 5'd0, 5'd0, 1, 0, 0);
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL raw_stall0 got=%0h exp=0", IN_READY); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL raw_stall_loop got=%0h exp=0", IN_READY); end
    end
    regs[3] = newval;
    RETIRE_VALID = 1; RETIRE_ADDR = 5'd3;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got=%0h exp=0", IN_READY); end
    step();
    RETIRE_VALID = 0;
    #1;
    checks++; if (BUSY_MASK !== 4'b0) begin errors++; $display("FAIL raw_busy_cleared got=%0b exp=0", BUSY_MASK); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL raw_unblock got=%0h exp=1", IN_READY); end
    step();
    clear_inputs();
    checks++; if (A1 !== 5'd3) begin errors++; $display("FAIL raw_a1 got=%0h exp=3", A1); end
    step();
    step();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL raw_valid got=%0h exp=1", OUT_VALID); end
    checks++; if (OUT_OP1 !== newval) begin errors++; $display("FAIL raw_op1 got=%0h exp=%0h", OUT_OP1, newval); end
    checks++; if (OUT_OP2 !== '0 || OUT_WE !== 1'b0) begin errors++; $display("FAIL raw_op2_we got=%0h/%0h exp=0/0", OUT_OP2, OUT_WE); end
    step();
  endtask

  task automatic test_waw_alias();
    present(5'd0, 5'd0, 5'd1, 0, 0, 1);
    step();
    clear_inputs();
    step(); step(); step();
    checks++; if (BUSY_MASK !== 4'b0010) begin errors++; $display("FAIL waw_pre_busy got=%0b exp=0010", BUSY_MASK); end
    present(5'd0, 5'd0, 5'd5, 0, 0, 1);
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL waw_stall got=%0h exp=0", IN_READY); end
    RETIRE_VALID = 1; RETIRE_ADDR = 5'd9;
    step();
    RETIRE_VALID = 0;
    #1;
    checks++; if (BUSY_MASK !== 4'b0000) begin errors++; $display("FAIL waw_alias_clear got=%0b exp=0000", BUSY_MASK); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL waw_unblock got=%0h exp=1", IN_READY); end
    step();
    clear_inputs();
    checks++; if (BUSY_MASK !== 4'b0010) begin errors++; $display("FAIL waw_reset_bit got=%0b exp=0010", BUSY_MASK); end
    step(); step();
    checks++; if (OUT_VALID !== 1'b1 || OUT_RD !== 5'd5 || OUT_WE !== 1'b1) begin errors++; $display("FAIL waw_bundle got v=%0h rd=%0h we=%0h exp 1/5/1", OUT_VALID, OUT_RD, OUT_WE); end
    step();
    RETIRE_VALID = 1; RETIRE_ADDR = 5'd1;
    step();
    RETIRE_VALID = 0;
    checks++; if (BUSY_MASK !== 4'b0) begin errors++; $display("FAIL waw_cleanup got=%0b exp=0", BUSY_MASK); end
  endtask

  task automatic test_backpressure();
    regs[2] = rand256(); regs[0] = rand256();
    OUT_READY = 0;
    present(5'd2, 5'd0, 5'd2, 1, 1, 0);
    step();
    clear_inputs();
    step(); step();
    present(5'd1, 5'd1, 5'd1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0h exp=1", OUT_VALID); end
      checks++; if (OUT_OP1 !== regs[2] || OUT_OP2 !== regs[0]) begin errors++; $display("FAIL bp_ops_stable got=%0h/%0h exp=%0h/%0h", OUT_OP1, OUT_OP2, regs[2], regs[0]); end
      checks++; if (OUT_RD !== 5'd2 || OUT_WE !== 1'b0) begin errors++; $display("FAIL bp_rd_we got=%0h/%0h exp=2/0", OUT_RD, OUT_WE); end
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0h exp=0", IN_READY); end
      step();
    end
    OUT_READY = 1;
    step();
    clear_inputs();
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_drop got=%0h exp=0", OUT_VALID); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%0h exp=1", IN_READY); end
  endtask

  task automatic test_unused_same_edge();
    regs[1] = rand256() | 256'h1; regs[2] = rand256() | 256'h1;
    OUT_READY = 1;
    present(5'd1, 5'd2, 5'd0, 0, 0, 1);
    RETIRE_VALID = 1; RETIRE_ADDR = 5'd0;
    step();
    clear_inputs();
    checks++; if (BUSY_MASK !== 4'b0001) begin errors++; $display("FAIL same_edge_set_wins got=%0b exp=0001", BUSY_MASK); end
    step(); step();
    checks++; if (OUT_VALID !== 1'b1 || OUT_OP1 !== '0 || OUT_OP2 !== '0) begin errors++; $display("FAIL unused_ops got v=%0h %0h/%0h exp 1/0/0", OUT_VALID, OUT_OP1, OUT_OP2); end
    step();
    RETIRE_VALID = 1; RETIRE_ADDR = 5'd0;
    step();
    RETIRE_VALID = 0;
  endtask

  task automatic test_reset_mid();
    regs[2] = rand256();
    present(5'd2, 5'd0, 5'd2, 1, 0, 1);
    step();
    clear_inputs();
    checks++; if (BUSY_MASK !== 4'b0100) begin errors++; $display("FAIL mid_busy_set got=%0b exp=0100", BUSY_MASK); end
    step();
    RST = 0;
    #1;
    checks++; if (BUSY_MASK !== 4'b0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset got busy=%0b v=%0h exp 0/0", BUSY_MASK, OUT_VALID); end
    step();
    RST = 1;
    step();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_no_bundle got=%0h exp=0", OUT_VALID); end
    present(5'd2, 5'd0, 5'd1, 1, 0, 0);
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL mid_ready got=%0h exp=1", IN_READY); end
    step();
    clear_inputs();
    step(); step();
    checks++; if (OUT_VALID !== 1'b1 || OUT_OP1 !== regs[2]) begin errors++; $display("FAIL mid_next got v=%0h op1=%0h exp 1/%0h", OUT_VALID, OUT_OP1, regs[2]); end
    step();
  endtask

  // Model: busy set/clear rules, one instruction in flight, bundle valid from accept+2 edges
  task automatic test_random();
    bit [3:0]     m_busy;
    bit           m_infl;
    int           cyc, m_acc;
    logic [4:0]   m_a1, m_a2, m_rd;
    bit           m_u1, m_u2, m_we;
    logic [255:0] m_op1, m_op2;
    bit           exp_ready, haz, exp_valid;
    int           r;
    do_reset();
    for (int i = 0; i < 4; i++) regs[i] = rand256();
    m_busy = 0; m_infl = 0; cyc = 0; m_acc = -10;
    m_a1 = 0; m_a2 = 0; m_rd = 0; m_u1 = 0; m_u2 = 0; m_we = 0;
    m_op1 = '0; m_op2 = '0;
    for (int it = 0; it < 400; it++) begin
      IN_VALID = ($urandom_range(0, 9) < 7);
      IN_RS1 = 5'($urandom); IN_RS2 = 5'($urandom); IN_RD = 5'($urandom);
      IN_USE_RS1 = 1'($urandom); IN_USE_RS2 = 1'($urandom); IN_WRITES_RD = 1'($urandom);
      OUT_READY = ($urandom_range(0, 9) < 6);
      RETIRE_VALID = 0; RETIRE_ADDR = 5'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, 3);
        RETIRE_VALID = 1;
        RETIRE_ADDR[1:0] = 2'(r);
        if (m_busy[r]) regs[r] = rand256();
      end
      #1;
      haz = (IN_USE_RS1 && m_busy[IN_RS1 % 4]) || (IN_USE_RS2 && m_busy[IN_RS2 % 4]) ||
            (IN_WRITES_RD && m_busy[IN_RD % 4]);
      exp_ready = !m_infl && !haz;
      checks++; if (IN_READY !== exp_ready) begin errors++; $display("FAIL rnd_in_ready it=%0d got=%0h exp=%0h", it, IN_READY, exp_ready); end
      @(posedge CLK_DC);
      cyc++;
      if (m_infl && cyc == m_acc + 1) begin
        m_op1 = m_u1 ? regs[m_a1 % 4] : '0;
        m_op2 = m_u2 ? regs[m_a2 % 4] : '0;
      end
      if (m_infl && cyc - 1 >= m_acc + 2 && OUT_READY) m_infl = 0;
      if (RETIRE_VALID) m_busy[RETIRE_ADDR % 4] = 0;
      if (IN_VALID && exp_ready) begin
        if (IN_WRITES_RD) m_busy[IN_RD % 4] = 1;
        m_infl = 1; m_acc = cyc;
        m_a1 = IN_RS1; m_a2 = IN_RS2; m_rd = IN_RD;
        m_u1 = IN_USE_RS1; m_u2 = IN_USE_RS2; m_we = IN_WRITES_RD;
      end
      #1;
      exp_valid = m_infl && (cyc >= m_acc + 2);
      checks++; if (BUSY_MASK !== m_busy) begin errors++; $display("FAIL rnd_busy it=%0d got=%0b exp=%0b", it, BUSY_MASK, m_busy); end
      checks++; if (A1 !== m_a1 || A2 !== m_a2) begin errors++; $display("FAIL rnd_addr it=%0d got=%0h/%0h exp=%0h/%0h", it, A1, A2, m_a1, m_a2); end
      checks++; if (OUT_VALID !== exp_valid) begin errors++; $display("FAIL rnd_valid it=%0d got=%0h exp=%0h", it, OUT_VALID, exp_valid); end
      if (exp_valid) begin
        checks++; if (OUT_OP1 !== m_op1 || OUT_OP2 !== m_op2) begin errors++; $display("FAIL rnd_ops it=%0d got=%0h/%0h exp=%0h/%0h", it, OUT_OP1, OUT_OP2, m_op1, m_op2); end
        checks++; if (OUT_RD !== m_rd || OUT_WE !== m_we) begin errors++; $display("FAIL rnd_rd_we it=%0d got=%0h/%0h exp=%0h/%0h", it, OUT_RD, OUT_WE, m_rd, m_we); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    RST = 0;
    OUT_READY = 1;
    clear_inputs();
    for (int i = 0; i < 4; i++) regs[i] = '0;
    #2;
    test_reset();
    test_basic();
    test_raw();
    test_waw_alias();
    test_backpressure();
    test_unused_same_edge();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
